// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: single-port word RAM fronted by a FIFO store buffer.
// Stores enqueue, drain on non-load cycles, and loads forward the youngest matching entry.
module dmem_store_buffer #(
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   proc2Dmem_command,
    input  logic [31:0]                  proc2Dmem_addr,
    input  logic [31:0]                  proc2mem_data,
    output logic [31:0]                  mem2proc_data,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [31:0]                  dbg_data,
    output logic [$clog2(SB_DEPTH):0]    sb_count,
    output logic                         sb_empty,
    output logic                         sb_full,
    output logic                         addr_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [31:0]   ram_q     [MEM_WORDS];
    logic [AW-1:0] sb_addr_q [SB_DEPTH];
    logic [31:0]   sb_data_q [SB_DEPTH];
    logic [PW:0]   head_q, head_d, tail_q, tail_d;
    logic          addr_err_q, addr_err_d;
    logic          is_load, is_store, in_range, enq, drain, hit;
    logic [AW-1:0] idx;
    logic [31:0]   fwd;
    logic          unused_ok;

    assign is_load   = proc2Dmem_command == BUS_LOAD;
    assign is_store  = proc2Dmem_command == BUS_STORE;
    assign in_range  = (proc2Dmem_addr >> (AW + 2)) == 32'd0;
    assign idx       = proc2Dmem_addr[AW+1:2];
    assign unused_ok = ^proc2Dmem_addr[1:0];
    assign sb_count  = tail_q - head_q;
    assign sb_empty  = sb_count == '0;
    assign sb_full   = sb_count == (PW+1)'(SB_DEPTH);
    assign addr_err  = addr_err_q;
    assign enq       = !rst && is_store && in_range;
    assign drain     = !rst && !is_load && !sb_empty;
    assign dbg_data  = ram_q[dbg_addr];

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((PW+1)'(i) < sb_count && sb_addr_q[head_q[PW-1:0] + PW'(i)] == idx) begin
                hit = 1'b1;
                fwd = sb_data_q[head_q[PW-1:0] + PW'(i)];
            end
        end
    end

    assign mem2proc_data = (!rst && is_load && in_range) ? (hit ? fwd : ram_q[idx]) : '0;

    always_comb begin
        head_d     = head_q + (PW+1)'(drain);
        tail_d     = tail_q + (PW+1)'(enq);
        addr_err_d = addr_err_q | ((is_load | is_store) & !in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            addr_err_q <= addr_err_d;
        end
    end

    // When full, tail and head share a slot: the old head is read into RAM as the new store overwrites it.
    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr_q[tail_q[PW-1:0]] <= idx;
            sb_data_q[tail_q[PW-1:0]] <= proc2mem_data;
        end
        if (drain)
            ram_q[sb_addr_q[head_q[PW-1:0]]] <= sb_data_q[head_q[PW-1:0]];
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed plus randomized checks against a queue-based memory model.
module tb_dmem_store_buffer;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    typedef struct {
        int          idx;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cmd = NONE;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [2:0]  sb_count;
    logic        sb_empty, sb_full, addr_err;

    logic [31:0] mram [1024];
    bit          written [1024];
    ent_t        q[$];
    bit          m_err;
    int          n_cmp = 0;
    int          n_err = 0;

    dmem_store_buffer dut (
        .clk(clk), .rst(rst),
        .proc2Dmem_command(cmd), .proc2Dmem_addr(addr), .proc2mem_data(wdata),
        .mem2proc_data(rdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .sb_count(sb_count), .sb_empty(sb_empty), .sb_full(sb_full), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs and compare every output against the model before the edge.
    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d, input int dbg);
        bit          have;
        logic [31:0] exp;
        int          wi;
        cmd = c; addr = a; wdata = d; dbg_addr = 10'(dbg);
        #1;
        wi   = int'(a / 4);
        have = 1'b1;
        exp  = '0;
        if (!rst && c == LOAD && a < 32'h1000) begin
            have = written[wi];
            exp  = mram[wi];
            foreach (q[k]) if (q[k].idx == wi) begin exp = q[k].d; have = 1'b1; end
        end
        if (have) chk("load_data", rdata, exp);
        chk("sb_count", 32'(sb_count), 32'(q.size()));
        chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        chk("sb_full", 32'(sb_full), 32'(q.size() == 4));
        chk("addr_err", 32'(addr_err), 32'(m_err));
        if (written[dbg]) chk("dbg_data", dbg_data, mram[dbg]);
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (cmd != LOAD && q.size() > 0) begin
                e = q.pop_front();
                mram[e.idx] = e.d;
                written[e.idx] = 1'b1;
            end
            if (cmd == STORE && addr < 32'h1000) begin
                e.idx = int'(addr / 4);
                e.d = wdata;
                q.push_back(e);
            end
            if ((cmd == LOAD || cmd == STORE) && addr >= 32'h1000) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        drive(c, a, d, int'($urandom_range(0, 127)));
        tick();
    endtask

    initial begin
        logic [1:0]  rc;
        logic [31:0] ra;
        tick();
        rst = 1'b0;
        drive(NONE, 0, 0, 0);
        chk("reset_count", 32'(sb_count), 0);
        chk("reset_empty", 32'(sb_empty), 1);
        tick();
        for (int i = 0; i < 128; i++) step(STORE, 32'(i * 4), $urandom);
        step(NONE, 0, 0);
        step(NONE, 0, 0);

        drive(STORE, 32'h100, 32'hDEADBEEF, 64); tick();
        drive(LOAD, 32'h100, 0, 64);
        chk("t1_fwd", rdata, 32'hDEADBEEF);
        chk("t1_count", 32'(sb_count), 1);
        tick();
        drive(NONE, 0, 0, 64); tick();
        drive(NONE, 0, 0, 64);
        chk("t1_ram", dbg_data, 32'hDEADBEEF);
        chk("t1_empty", 32'(sb_empty), 1);
        tick();

        for (int i = 1; i <= 3; i++) step(STORE, 32'h20, 32'(i));
        for (int i = 0; i < 3; i++) begin
            drive(LOAD, 32'h20, 0, 8);
            chk("t2_youngest", rdata, 3);
            tick();
        end
        for (int i = 0; i < 3; i++) step(NONE, 0, 0);
        drive(NONE, 0, 0, 8);
        chk("t2_ram", dbg_data, 3);
        tick();

        for (int i = 0; i < 6; i++) step(LOAD, 32'(i * 4), 0);
        for (int i = 0; i < 10; i++) step(STORE, 32'(32'h40 + i * 4), $urandom);
        drive(NONE, 0, 0, 25);
        chk("t3_count", 32'(sb_count), 1);
        tick();
        for (int i = 0; i < 4; i++) step(NONE, 0, 0);
        for (int i = 0; i < 10; i++) begin drive(NONE, 0, 0, 16 + i); tick(); end

        for (int i = 0; i < 5; i++) begin
            step(STORE, 32'(32'h80 + i * 4), $urandom);
            step(LOAD, 32'(32'h1F0 - i * 4), 0);
        end
        for (int i = 0; i < 5; i++) begin drive(NONE, 0, 0, 32 + i); tick(); end

        drive(STORE, 32'h1000, 32'h12345678, 0);
        chk("t5_err_before", 32'(addr_err), 0);
        tick();
        drive(LOAD, 32'h1000, 0, 0);
        chk("t5_err_set", 32'(addr_err), 1);
        chk("t5_oor_load", rdata, 0);
        tick();
        for (int i = 0; i < 3; i++) step(NONE, 0, 0);

        for (int i = 0; i < 3; i++) step(STORE, 32'(32'h60 + i * 4), $urandom);
        rst = 1'b1;
        drive(LOAD, 32'h60, 0, 24);
        chk("t6_rst_load", rdata, 0);
        tick();
        rst = 1'b0;
        drive(NONE, 0, 0, 26);
        chk("t6_count", 32'(sb_count), 0);
        chk("t6_err", 32'(addr_err), 0);
        tick();

        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            rc  = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) ra = 32'(($urandom_range(0, 7)) * 4);
            step(rc, ra, $urandom);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(NONE, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
